// File: rtl/act_lut_fetcher_if.sv
// ============================================================================
//  Module   : act_lut_fetcher_if
//  Purpose  : Bundles the sample input, table memory and interpolator output
//             handshakes of the activation LUT fetcher.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface act_lut_fetcher_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   x;
    logic                mem_rd;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_rdata;
    logic                tbl_wr;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   base;
    logic [DATA_W-1:0]   next_data;
    logic [DATA_W-1:0]   remaining;

    modport slave (
        input  in_valid, x, mem_rdata, tbl_wr, out_ready,
        output in_ready, mem_rd, mem_addr, out_valid, base, next_data, remaining
    );

    modport master (
        output in_valid, x, mem_rdata, tbl_wr, out_ready,
        input  in_ready, mem_rd, mem_addr, out_valid, base, next_data, remaining
    );
endinterface

`default_nettype wire

// File: rtl/act_lut_fetcher.sv
// ============================================================================
//  Module   : act_lut_fetcher
//  Purpose  : Splits a fixed-point pre-activation into table index and
//             fraction, fetches table[a] and table[a+1] and presents them to
//             the interpolator. Define ACT_LUT_REUSE_EN to skip the reads when
//             the address repeats and the table has not been rewritten.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module act_lut_fetcher #(
    parameter int DATA_W     = 8,
    parameter int FRAC_W     = 4,
    parameter int ADDR_W     = 5,
    parameter int TBL_OFFSET = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    act_lut_fetcher_if.slave   bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_BASE = 3'd1;
    localparam logic [2:0] S_RD_NEXT = 3'd2;
    localparam logic [2:0] S_CAPT    = 3'd3;
    localparam logic [2:0] S_OUT     = 3'd4;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_a;
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_base;
    logic [DATA_W-1:0] r_next;
    logic [DATA_W-1:0] r_rem;

    logic [ADDR_W-1:0] w_a;
    logic [DATA_W-1:0] w_rem;
    logic              w_accept;
    logic              w_hit;

    // Truncating to ADDR_W after the add equals adding in ADDR_W bits.
    assign w_a      = ADDR_W'($signed(bus.x) >>> FRAC_W) + ADDR_W'(TBL_OFFSET);
    assign w_rem    = DATA_W'(bus.x[FRAC_W-1:0]);
    assign w_accept = (r_state == S_IDLE) && bus.in_valid;

`ifdef ACT_LUT_REUSE_EN
    logic [ADDR_W-1:0] r_last_a;
    logic              r_cache_vld;

    assign w_hit = r_cache_vld && (w_a == r_last_a) && !bus.tbl_wr;

    // A table write wins over the set on OUT entry: captured data may be stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cache_vld <= 1'b0;
            r_last_a    <= '0;
        end else begin
            if (bus.tbl_wr) begin
                r_cache_vld <= 1'b0;
            end else if (r_state == S_CAPT) begin
                r_cache_vld <= 1'b1;
            end
            if (w_accept && !w_hit) begin
                r_last_a <= w_a;
            end
        end
    end
`else
    logic w_unused_tbl_wr;

    assign w_hit           = 1'b0;
    assign w_unused_tbl_wr = bus.tbl_wr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_base     <= '0;
            r_next     <= '0;
            r_rem      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rem <= w_rem;
                        r_a   <= w_a;
                        if (w_hit) begin
                            r_state <= S_OUT;
                        end else begin
                            r_state    <= S_RD_BASE;
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= w_a;
                        end
                    end
                end
                S_RD_BASE: begin
                    r_mem_addr <= r_a + ADDR_W'(1);
                    r_state    <= S_RD_NEXT;
                end
                S_RD_NEXT: begin
                    r_mem_rd <= 1'b0;
                    r_base   <= bus.mem_rdata;
                    r_state  <= S_CAPT;
                end
                S_CAPT: begin
                    r_next  <= bus.mem_rdata;
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_mem_rd <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_OUT);
    assign bus.mem_rd    = r_mem_rd;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.base      = r_base;
    assign bus.next_data = r_next;
    assign bus.remaining = r_rem;

endmodule

`default_nettype wire
